// File: rtl/syzygy_adc_pkg.sv
// Shared definitions for the SYZYGY ADC capture path: FSM state encoding,
// default counter width and the pipeline latency of each supported ADC part.
package syzygy_adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef enum logic [0:0] {
    ADC_PART_GENERIC = 1'b0,
    ADC_PART_AD9648  = 1'b1
  } adc_part_e;

  localparam int DATA_W_DEFAULT         = 12;
  localparam int COUNT_W_DEFAULT        = 16;
  localparam int LATENCY_GENERIC        = 8;
  localparam int LATENCY_AD9648         = 10;
  localparam int LATENCY_DEFAULT        = LATENCY_GENERIC;

  // Encode-cycle pipeline latency of a given ADC part.
  function automatic int latency_for_part(input adc_part_e part);
    case (part)
      ADC_PART_AD9648: return LATENCY_AD9648;
      default:         return LATENCY_GENERIC;
    endcase
  endfunction

endpackage

// File: rtl/syzygy_adc_if.sv
// Bundle between host/ADC environment and the capture controller.
// slave = controller side, master = environment side.
interface syzygy_adc_if #(
  parameter int DATA_W  = syzygy_adc_pkg::DATA_W_DEFAULT,
  parameter int COUNT_W = syzygy_adc_pkg::COUNT_W_DEFAULT
);
  logic               start;
  logic               abort;
  logic [COUNT_W-1:0] sample_count;
  logic [DATA_W-1:0]  adc_data;
  logic               enc_en;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               done;
  logic               overflow;
  logic               enc_clk_p;
  logic               enc_clk_n;

  modport slave (
    input  start, abort, sample_count, adc_data, out_ready,
    output enc_en, out_data, out_valid, busy, done, overflow,
           enc_clk_p, enc_clk_n
  );

  modport master (
    output start, abort, sample_count, adc_data, out_ready,
    input  enc_en, out_data, out_valid, busy, done, overflow,
           enc_clk_p, enc_clk_n
  );
endinterface

// File: rtl/syzygy_adc_enc_gated.sv
// Encode clock output stage: behavioural ODDR (D1=enc_en, D2=0) followed by
// a differential buffer. D1 is captured on the rising edge and shown during
// the high phase; the low phase always carries D2=0, so gating never glitches.
module syzygy_adc_enc_gated (
  input  logic clk,
  input  logic rst_n,
  input  logic enc_en,
  output logic enc_clk_p,
  output logic enc_clk_n
);

  logic d1_d;
  logic d1_q;

  // Next value of the rising-edge data register.
  always_comb begin
    d1_d = enc_en;
  end

  // Rising-edge capture of D1.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) d1_q <= 1'b0;
    else        d1_q <= d1_d;
  end

  assign enc_clk_p = clk ? d1_q : 1'b0;
  assign enc_clk_n = ~enc_clk_p;

endmodule

// File: rtl/syzygy_adc_capture_ctrl.sv
// ADC burst sequencer: on start, enables the encode clock, waits out the ADC
// pipeline latency, forwards exactly N samples and pulses done.
// One flat FSM with a single down-counter reloaded on every state entry.
module syzygy_adc_capture_ctrl
  import syzygy_adc_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int COUNT_W = COUNT_W_DEFAULT,
  parameter int LATENCY = LATENCY_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  syzygy_adc_if.slave       bus
);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] n_q, n_d;
  logic               enc_en_q, enc_en_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;

  // Next-state, counter and registered-output logic.
  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q | (out_valid_q & ~bus.out_ready);

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          n_d        = bus.sample_count;
          overflow_d = 1'b0;
          if (bus.sample_count == '0) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            state_d = ST_WARMUP;
            cnt_d   = COUNT_W'(LATENCY);
          end
        end
      end
      ST_WARMUP: begin
        if (cnt_q == COUNT_W'(1)) begin
          state_d = ST_CAPTURE;
          cnt_d   = n_q;
        end else begin
          cnt_d = cnt_q - COUNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        out_data_d  = bus.adc_data;
        out_valid_d = 1'b1;
        if (cnt_q == COUNT_W'(1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - COUNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort drops straight back to idle: no done, no further beats,
    // overflow left as it is.
    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
    end

    enc_en_d = (state_d == ST_WARMUP) || (state_d == ST_CAPTURE);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      enc_en_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      enc_en_q    <= enc_en_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.enc_en    = enc_en_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.overflow  = overflow_q;

  syzygy_adc_enc_gated u_enc (
    .clk       (clk),
    .rst_n     (rst_n),
    .enc_en    (enc_en_q),
    .enc_clk_p (bus.enc_clk_p),
    .enc_clk_n (bus.enc_clk_n)
  );

endmodule

// File: tb/tb_syzygy_adc_capture_ctrl.sv
// Directed bench for syzygy_adc_capture_ctrl (LATENCY=8). Each scenario is a
// record of stimulus plus expected output windows in bench cycle numbers;
// adc_data carries the cycle number so out_data during a beat must be c-1.
module tb_syzygy_adc_capture_ctrl;

  localparam int DATA_W  = 12;
  localparam int COUNT_W = 16;
  localparam int LATENCY = 8;

  typedef struct {
    string       name;
    int          n;
    logic [63:0] start_mask;
    int          abort_cyc;
    int          rdy_low_cyc;
    int          enc_lo, enc_hi;
    int          val_lo, val_hi;
    int          busy_lo, busy_hi;
    int          done_cyc;
    int          ovf_lo, ovf_hi;
    int          last;
    int          follow;   // 0 none, 1 restart check, 2 overflow-clear check
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   c = 0;
  int   tests = 0;
  int   fails = 0;

  syzygy_adc_if #(.DATA_W(DATA_W), .COUNT_W(COUNT_W)) bus ();

  syzygy_adc_capture_ctrl #(
    .DATA_W (DATA_W),
    .COUNT_W(COUNT_W),
    .LATENCY(LATENCY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, c, act, exp);
    end
  endtask

  function automatic logic in_win(input int cy, input int lo, input int hi);
    return (cy >= lo) && (cy <= hi);
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    c++;
    bus.adc_data = DATA_W'(c);
  endtask

  task automatic idle_inputs();
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.sample_count = '0;
    bus.out_ready    = 1'b1;
    bus.adc_data     = '0;
  endtask

  // Two reset edges, then cycle numbering restarts at 0 with rst_n released.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    c = 0;
    bus.adc_data = '0;
  endtask

  function automatic vec_t mk(input string name, input int n, input logic [63:0] mask,
                              input int ab, input int rl, input int el, input int eh,
                              input int vl, input int vh, input int bl, input int bh,
                              input int dc, input int ol, input int oh, input int last,
                              input int follow);
    vec_t v;
    v.name = name; v.n = n; v.start_mask = mask; v.abort_cyc = ab; v.rdy_low_cyc = rl;
    v.enc_lo = el; v.enc_hi = eh; v.val_lo = vl; v.val_hi = vh;
    v.busy_lo = bl; v.busy_hi = bh; v.done_cyc = dc; v.ovf_lo = ol; v.ovf_hi = oh;
    v.last = last; v.follow = follow;
    return v;
  endfunction

  // After the ignored starts, the start at 24 (sample_count=7) must run a full burst.
  task automatic restart_followup();
    int beats;
    int done_at;
    logic [DATA_W-1:0] last_data;
    check("restart.enc_en_25", 32'(bus.enc_en), 32'd1);
    check("restart.busy_25", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    beats = 0;
    done_at = -1;
    last_data = '0;
    for (int k = 0; k < 40; k++) begin
      if (bus.out_valid) beats++;
      if (bus.done) begin
        done_at = c;
        last_data = bus.out_data;
        break;
      end
      tick();
    end
    check("restart.done_cycle", 32'(done_at), 32'd40);
    check("restart.beats", 32'(beats), 32'd7);
    check("restart.last_data", 32'(last_data), 32'd39);
  endtask

  // Sticky overflow survives done and is cleared by the next accepted start.
  task automatic ovf_followup();
    check("ovf.held_after_done", 32'(bus.overflow), 32'd1);
    bus.start = 1'b1;
    bus.sample_count = 16'd2;
    tick();
    bus.start = 1'b0;
    check("ovf.cleared_on_start", 32'(bus.overflow), 32'd0);
    check("ovf.busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  // Reset asserted mid-burst, then a fresh one-sample burst.
  task automatic reset_sequence();
    do_reset();
    for (int k = 0; k <= 31; k++) begin
      if (c == 18) check("rst.enc_before", 32'(bus.enc_en), 32'd1);
      if (c == 19) begin
        check("rst.enc_en", 32'(bus.enc_en), 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.out_data", 32'(bus.out_data), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.overflow", 32'(bus.overflow), 32'd0);
      end
      if (c == 21) check("rst.restart_enc", 32'(bus.enc_en), 32'd1);
      if (c == 29) check("rst.done_early", 32'(bus.done), 32'd0);
      if (c == 30) begin
        check("rst.done", 32'(bus.done), 32'd1);
        check("rst.valid_last", 32'(bus.out_valid), 32'd1);
        check("rst.data_last", 32'(bus.out_data), 32'd29);
      end
      if (c == 31) check("rst.idle_after", 32'(bus.busy), 32'd0);
      bus.start        = (c == 10) || (c == 20);
      bus.sample_count = (c == 20) ? 16'd1 : 16'd4;
      rst_n            = (c != 18);
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t vecs[7];
    vec_t r;
    logic [63:0] m10;
    logic [63:0] mrest;
    m10 = 64'd1 << 10;
    mrest = (64'd1 << 10) | (64'd1 << 12) | (64'd1 << 15) | (64'd1 << 23) | (64'd1 << 24);

    //          name      n  mask  abort rdy  enc      val      busy     done  ovf        last fol
    vecs[0] = mk("basic",  4, m10,   -1, -1,  11, 22,  20, 23,  11, 23,  23,   1, 0,    30,  0);
    vecs[1] = mk("zero",   0, m10,   -1, -1,   1, 0,    1, 0,   11, 11,  11,   1, 0,    16,  0);
    vecs[2] = mk("ab_warm",4, m10,   15, -1,  11, 15,   1, 0,   11, 15,  -1,   1, 0,    26,  0);
    vecs[3] = mk("ab_cap", 4, m10,   21, -1,  11, 21,  20, 21,  11, 21,  -1,   1, 0,    28,  0);
    vecs[4] = mk("ab_start",4, m10,  10, -1,   1, 0,    1, 0,    1, 0,   -1,   1, 0,    14,  0);
    vecs[5] = mk("restart",4, mrest, -1, -1,  11, 22,  20, 23,  11, 23,  23,   1, 0,    24,  1);
    vecs[6] = mk("ovf",    4, m10,   -1, 21,  11, 22,  20, 23,  11, 23,  23,  22, 1000, 28,  2);

    idle_inputs();
    for (int i = 0; i < 7; i++) begin
      r = vecs[i];
      do_reset();
      for (int k = 0; k <= r.last; k++) begin
        check({r.name, ".enc_en"},   32'(bus.enc_en),    32'(in_win(c, r.enc_lo, r.enc_hi)));
        check({r.name, ".out_valid"},32'(bus.out_valid), 32'(in_win(c, r.val_lo, r.val_hi)));
        check({r.name, ".busy"},     32'(bus.busy),      32'(in_win(c, r.busy_lo, r.busy_hi)));
        check({r.name, ".done"},     32'(bus.done),      32'(c == r.done_cyc));
        check({r.name, ".overflow"}, 32'(bus.overflow),  32'(in_win(c, r.ovf_lo, r.ovf_hi)));
        if (in_win(c, r.val_lo, r.val_hi))
          check({r.name, ".out_data"}, 32'(bus.out_data), 32'(c - 1));
        bus.start        = r.start_mask[k];
        bus.abort        = (c == r.abort_cyc);
        bus.out_ready    = (c != r.rdy_low_cyc);
        bus.sample_count = (c <= 10) ? COUNT_W'(r.n) : COUNT_W'(7);
        tick();
      end
      bus.abort = 1'b0;
      bus.out_ready = 1'b1;
      if (r.follow == 1) restart_followup();
      else if (r.follow == 2) ovf_followup();
    end

    reset_sequence();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
